// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the data-memory path: processor word
//                width, bridge FSM state encoding and the read-timeout value.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

   localparam int WORD_SIZE = 16;

   // Data returned to the processor when a load times out
   localparam logic [15:0] ERR_DATA = 16'hDEAD;

   typedef enum logic [1:0] {
      BR_IDLE  = 2'd0,
      BR_WRITE = 2'd1,
      BR_READ  = 2'd2,
      BR_RDONE = 2'd3
   } bridge_state_t;

   // True in the states that hold a memory transaction open
   function automatic logic br_in_txn(input bridge_state_t s);
      return (s == BR_WRITE) || (s == BR_READ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : write_buffer
//  Description : Posted-write FIFO holding {addr, data} entries. Head and tail
//                pointers wrap modulo DEPTH; the count is one bit wider so a
//                full buffer is distinguishable from an empty one.
//  Revision    : 1.0 - initial release
// ============================================================================
module write_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   // Status and next-pointer computation; full/empty come from registered count
   always_comb begin
      full    = (count_q == FULL_COUNT);
      empty   = (count_q == '0);
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (push_ok) begin
         tail_d = tail_q + PTR_W'(1);
      end
      if (pop_ok) begin
         head_d = head_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; contents are don't-care until pushed, so no reset
   always_ff @(posedge Clock) begin
      if (push_ok) begin
         entry_q[tail_q] <= push_data;
      end
   end

   assign head_data = entry_q[head_q];
   assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_bridge
//  Description : Processor data port to variable-latency single-port memory.
//                Stores are posted into a write buffer; loads block until the
//                buffer has drained and the read data returns. A watchdog
//                aborts any transaction left unacknowledged for TIMEOUT
//                cycles and raises a sticky bus error.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bridge #(
   parameter int                    WORD_SIZE  = mem_pkg::WORD_SIZE,
   parameter int                    WBUF_DEPTH = 4,
   parameter int                    TIMEOUT    = 255,
   parameter logic [WORD_SIZE-1:0]  ERR_DATA   = mem_pkg::ERR_DATA
) (
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic [WORD_SIZE-1:0]          DataAddr,
   input  logic [WORD_SIZE-1:0]          DataOut,
   input  logic                          WriteData,
   input  logic                          ReadData,
   output logic [WORD_SIZE-1:0]          DataIn,
   output logic                          DataWaitreq,
   output logic [WORD_SIZE-1:0]          mem_addr,
   output logic [WORD_SIZE-1:0]          mem_wdata,
   output logic                          mem_we,
   output logic                          mem_req,
   input  logic                          mem_ack,
   input  logic [WORD_SIZE-1:0]          mem_rdata,
   input  logic                          err_clear,
   output logic                          bus_error,
   output logic [$clog2(WBUF_DEPTH):0]   buf_count
);

   import mem_pkg::*;

   localparam int TO_W = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   bridge_state_t          state_q, state_d;
   logic                   mem_req_q, mem_req_d;
   logic                   mem_we_q, mem_we_d;
   logic [WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
   logic [WORD_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
   logic [WORD_SIZE-1:0]   rdata_q, rdata_d;
   logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
   logic                   bus_error_q, bus_error_d;

   logic                   wb_push;
   logic                   wb_pop;
   logic                   wb_full;
   logic                   wb_empty;
   logic [2*WORD_SIZE-1:0] wb_head;
   logic                   timeout_hit;

   write_buffer #(
      .WIDTH (2 * WORD_SIZE),
      .DEPTH (WBUF_DEPTH)
   ) u_wbuf (
      .Clock     (Clock),
      .Reset     (Reset),
      .push      (wb_push),
      .push_data ({DataAddr, DataOut}),
      .pop       (wb_pop),
      .head_data (wb_head),
      .full      (wb_full),
      .empty     (wb_empty),
      .count     (buf_count)
   );

   // Processor handshake: stores stall only on a full buffer and take priority
   // over a simultaneous load; loads stall until the data is presented
   always_comb begin
      wb_push     = WriteData && !wb_full;
      timeout_hit = mem_req_q && !mem_ack && (to_cnt_q == TO_LAST);
      wb_pop      = (state_q == BR_WRITE) && (mem_ack || timeout_hit);
      if (WriteData) begin
         DataWaitreq = wb_full;
      end else begin
         DataWaitreq = ReadData && (state_q != BR_RDONE);
      end
   end

   // Next-state and registered-output computation for the transaction FSM
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      to_cnt_d    = '0;

      case (state_q)
         BR_IDLE: begin
            // Draining posted stores comes before any load
            if (!wb_empty) begin
               state_d     = BR_WRITE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = wb_head[2*WORD_SIZE-1:WORD_SIZE];
               mem_wdata_d = wb_head[WORD_SIZE-1:0];
            end else if (ReadData && !WriteData) begin
               state_d    = BR_READ;
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = DataAddr;
            end
         end
         BR_WRITE: begin
            // Acked or timed out, the head entry is retired either way
            if (mem_ack || timeout_hit) begin
               state_d   = BR_IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         BR_READ: begin
            if (mem_ack) begin
               state_d   = BR_RDONE;
               mem_req_d = 1'b0;
               rdata_d   = mem_rdata;
            end else if (timeout_hit) begin
               state_d   = BR_RDONE;
               mem_req_d = 1'b0;
               rdata_d   = ERR_DATA;
            end
         end
         BR_RDONE: begin
            state_d = BR_IDLE;
         end
         default: begin
            state_d   = BR_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase

      // Staying in a transaction state means req is high and no ack came
      if (br_in_txn(state_q) && (state_d == state_q)) begin
         to_cnt_d = to_cnt_q + TO_W'(1);
      end

      // A fresh timeout overrides a clear in the same cycle
      if (timeout_hit) begin
         bus_error_d = 1'b1;
      end else if (err_clear) begin
         bus_error_d = 1'b0;
      end else begin
         bus_error_d = bus_error_q;
      end
   end

   // FSM state and every registered output
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q     <= BR_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         to_cnt_q    <= '0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         to_cnt_q    <= to_cnt_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign DataIn    = rdata_q;
   assign bus_error = bus_error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_bridge
//  Description : Scoreboard bench for data_mem_bridge. A reference memory
//                array predicts load data; a memory model answers requests
//                with programmable latency and checks the write stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_bridge;

   localparam int W     = 16;
   localparam int DEPTH = 4;
   localparam int TO    = 8;
   localparam int CW    = 3;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic [W-1:0]  DataAddr = '0;
   logic [W-1:0]  DataOut = '0;
   logic          WriteData = 1'b0;
   logic          ReadData = 1'b0;
   logic [W-1:0]  DataIn;
   logic          DataWaitreq;
   logic [W-1:0]  mem_addr;
   logic [W-1:0]  mem_wdata;
   logic          mem_we;
   logic          mem_req;
   logic          mem_ack = 1'b0;
   logic [W-1:0]  mem_rdata = '0;
   logic          err_clear = 1'b0;
   logic          bus_error;
   logic [CW-1:0] buf_count;

   always #5 Clock = ~Clock;

   data_mem_bridge #(
      .WORD_SIZE  (W),
      .WBUF_DEPTH (DEPTH),
      .TIMEOUT    (TO),
      .ERR_DATA   (16'hDEAD)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .DataAddr    (DataAddr),
      .DataOut     (DataOut),
      .WriteData   (WriteData),
      .ReadData    (ReadData),
      .DataIn      (DataIn),
      .DataWaitreq (DataWaitreq),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_we      (mem_we),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .err_clear   (err_clear),
      .bus_error   (bus_error),
      .buf_count   (buf_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference memory (what a load must return) and the memory model contents
   logic [W-1:0] ref_mem   [256];
   logic [W-1:0] mem_model [256];
   logic [31:0]  exp_wr [$];
   logic [W-1:0] exp_rd [$];

   // Memory model controls and observations
   bit           no_ack = 1'b0;
   int           lat_min = 0;
   int           lat_max = 0;
   int           cur_lat = 0;
   int           lat_cnt = 0;
   bit           acked = 1'b0;
   bit           prev_req = 1'b0;
   bit           prev_we = 1'b0;
   logic [W-1:0] prev_addr = '0;
   logic [W-1:0] prev_wdata = '0;
   int           req_run = 0;
   int           last_run = 0;
   int           req_rises = 0;

   initial begin
      for (int i = 0; i < 256; i++) begin
         ref_mem[i]   = W'(i * 257) ^ 16'h5A5A;
         mem_model[i] = W'(i * 257) ^ 16'h5A5A;
      end
   end

   // Memory model and write-stream monitor
   initial begin
      forever begin
         @(negedge Clock);
         if (Reset) begin
            mem_ack  = 1'b0;
            lat_cnt  = 0;
            prev_req = 1'b0;
            req_run  = 0;
            acked    = 1'b0;
         end else begin
            if (mem_ack) mem_ack = 1'b0;
            if (prev_req && mem_req) begin
               check("mem_addr_stable", mem_addr, prev_addr);
               check("mem_we_stable", mem_we, prev_we);
               check("mem_wdata_stable", mem_wdata, prev_wdata);
            end
            if (!prev_req && mem_req) begin
               req_rises++;
               req_run = 0;
               lat_cnt = 0;
               acked   = 1'b0;
               cur_lat = $urandom_range(lat_max, lat_min);
            end
            if (prev_req && !mem_req) begin
               last_run = req_run;
               if (!acked && prev_we) begin
                  if (exp_wr.size() == 0) check("dropped_write_expected", 1, 0);
                  else check("dropped_write", {prev_addr, prev_wdata}, exp_wr.pop_front());
               end
            end
            if (mem_req) begin
               req_run++;
               if (!no_ack && !acked && lat_cnt >= cur_lat) begin
                  mem_ack = 1'b1;
                  acked   = 1'b1;
                  if (mem_we) begin
                     mem_model[mem_addr[7:0]] = mem_wdata;
                     if (exp_wr.size() == 0) check("write_expected", 1, 0);
                     else check("mem_write", {mem_addr, mem_wdata}, exp_wr.pop_front());
                  end else begin
                     mem_rdata = mem_model[mem_addr[7:0]];
                  end
               end else begin
                  lat_cnt++;
               end
            end
            prev_req   = mem_req;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
         end
      end
   end

   // Load-completion monitor
   initial begin
      forever begin
         @(negedge Clock);
         if (!Reset && ReadData && !WriteData && !DataWaitreq) begin
            if (exp_rd.size() == 0) check("load_expected", 1, 0);
            else check("load_data", DataIn, exp_rd.pop_front());
         end
      end
   end

   // Store; called and returns just after a rising edge
   task automatic store(input logic [W-1:0] a, input logic [W-1:0] d, input bit drop,
                        output int waits);
      DataAddr  = a;
      DataOut   = d;
      WriteData = 1'b1;
      ReadData  = 1'b0;
      waits     = 0;
      forever begin
         @(negedge Clock);
         if (!DataWaitreq) break;
         waits++;
         if (waits > 300) begin
            check("store_accept_timeout", 0, 1);
            break;
         end
      end
      exp_wr.push_back({a, d});
      if (!drop) ref_mem[a[7:0]] = d;
      @(posedge Clock);
      #1;
      WriteData = 1'b0;
   endtask

   // Load; use_err predicts a timed-out read
   task automatic load(input logic [W-1:0] a, input bit use_err, output int stall);
      DataAddr  = a;
      ReadData  = 1'b1;
      WriteData = 1'b0;
      exp_rd.push_back(use_err ? 16'hDEAD : ref_mem[a[7:0]]);
      stall = 0;
      forever begin
         @(negedge Clock);
         if (!DataWaitreq) break;
         stall++;
         if (stall > 300) begin
            check("load_complete_timeout", 0, 1);
            break;
         end
      end
      @(posedge Clock);
      #1;
      ReadData = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(negedge Clock);
         if (buf_count == 0 && !mem_req && !mem_ack) break;
         n++;
         if (n > 500) begin
            check("drain_timeout", 0, 1);
            break;
         end
      end
      repeat (2) @(posedge Clock);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w [5];
      int st;
      int n;
      int rises;
      logic [W-1:0] ra;

      repeat (3) @(negedge Clock);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_DataIn", DataIn, 0);
      check("rst_bus_error", bus_error, 0);
      check("rst_buf_count", buf_count, 0);
      check("rst_DataWaitreq", DataWaitreq, 0);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(posedge Clock);
      #1;

      // Store burst with fixed latency 3
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 5; i++) store(W'(16'h10 + i), W'(16'hA000 + i), 1'b0, w[i]);
      for (int i = 0; i < 4; i++) check($sformatf("burst_wait%0d", i), w[i], 0);
      check("burst_fifth_stalls", (w[4] > 0), 1);
      wait_idle();

      // Minimum-latency load
      lat_min = 0; lat_max = 0;
      mem_model[8'h50] = 16'hBEEF;
      ref_mem[8'h50]   = 16'hBEEF;
      load(16'h0050, 1'b0, st);
      check("min_load_stall", st, 2);
      check("min_load_DataIn", DataIn, 16'hBEEF);
      check("min_load_req_cycles", last_run, 1);
      wait_idle();

      // Load ordered behind a posted store
      lat_min = 2; lat_max = 2;
      store(16'h0020, 16'h1234, 1'b0, st);
      load(16'h0020, 1'b0, st);
      check("order_load_waited", (st > 2), 1);
      wait_idle();

      // Read timeout
      no_ack = 1'b1;
      load(16'h0060, 1'b1, st);
      no_ack = 1'b0;
      check("rd_timeout_req_cycles", last_run, TO);
      check("rd_timeout_bus_error", bus_error, 1);
      err_clear = 1'b1;
      @(posedge Clock);
      #1;
      err_clear = 1'b0;
      @(negedge Clock);
      check("err_clear", bus_error, 0);
      @(posedge Clock);
      #1;

      // Write timeout: first entry discarded, next entry issues
      lat_min = 1; lat_max = 1;
      no_ack = 1'b1;
      store(16'h0070, 16'h7777, 1'b1, st);
      store(16'h0071, 16'h7171, 1'b0, st);
      n = 0;
      forever begin
         @(negedge Clock);
         if (bus_error) break;
         n++;
         if (n > 100) begin
            check("wr_timeout_seen", 0, 1);
            break;
         end
      end
      no_ack = 1'b0;
      check("wr_timeout_count", buf_count, 1);
      check("wr_timeout_req_cycles", last_run, TO);
      wait_idle();
      check("wr_timeout_err_sticky", bus_error, 1);
      load(16'h0070, 1'b0, st);
      load(16'h0071, 1'b0, st);
      err_clear = 1'b1;
      @(posedge Clock);
      #1;
      err_clear = 1'b0;

      // Reset during READ with two buffered stores
      no_ack   = 1'b1;
      DataAddr = 16'h0030;
      ReadData = 1'b1;
      @(negedge Clock);
      @(negedge Clock);
      @(posedge Clock);
      #1;
      ReadData  = 1'b0;
      WriteData = 1'b1;
      DataAddr  = 16'h0031;
      DataOut   = 16'h1111;
      @(posedge Clock);
      #1;
      DataAddr  = 16'h0032;
      DataOut   = 16'h2222;
      @(posedge Clock);
      #1;
      WriteData = 1'b0;
      @(negedge Clock);
      check("pre_reset_count", buf_count, 2);
      check("pre_reset_req", mem_req, 1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_reset_req", mem_req, 0);
      check("async_reset_count", buf_count, 0);
      check("async_reset_waitreq", DataWaitreq, 0);
      repeat (2) @(posedge Clock);
      #1;
      Reset  = 1'b0;
      no_ack = 1'b0;
      rises  = req_rises;
      repeat (10) @(negedge Clock);
      check("post_reset_no_stale_req", req_rises - rises, 0);
      check("post_reset_count", buf_count, 0);
      check("post_reset_DataIn", DataIn, 0);
      @(posedge Clock);
      #1;

      // Randomized mixed traffic
      lat_min = 0; lat_max = 4;
      for (int i = 0; i < 60; i++) begin
         ra = W'(16'h40 + $urandom_range(15, 0));
         if ($urandom_range(9, 0) < 6) store(ra, W'($urandom), 1'b0, st);
         else load(ra, 1'b0, st);
      end
      wait_idle();
      load(16'h0014, 1'b0, st);
      load(16'h0010, 1'b0, st);

      check("writes_all_seen", exp_wr.size(), 0);
      check("loads_all_seen", exp_rd.size(), 0);
      check("final_bus_error", bus_error, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_bridge.md
# data_mem_bridge

Bridge between the processor's data port (memory stage) and a variable-latency single-port data memory. It absorbs stores into a posted write buffer so stores complete without stalling. Loads run as blocking transactions that drive `DataWaitreq` until data returns. A timeout watchdog guards every memory transaction and raises a sticky bus error.

## Interface

**Parameters**
- `WORD_SIZE`, default 16: data and address width.
- `WBUF_DEPTH`, default 4: number of posted-write entries; a power of two, at least 2.
- `TIMEOUT`, default 255: number of cycles `mem_req` may stay high without `mem_ack` before the transaction aborts.
- `ERR_DATA`, default 16'hDEAD: value returned to the processor on a read timeout.

**Ports**
- `Clock`, in, 1: clock.
- `Reset`, in, 1: reset, asynchronous, active-high.
- `DataAddr`, in, WORD_SIZE: processor data address.
- `DataOut`, in, WORD_SIZE: processor store data.
- `WriteData`, in, 1: processor store request.
- `ReadData`, in, 1: processor load request.
- `DataIn`, out, WORD_SIZE: load data to the processor.
- `DataWaitreq`, out, 1: stall request to the processor; combinational.
- `mem_addr`, out, WORD_SIZE: memory address.
- `mem_wdata`, out, WORD_SIZE: memory write data.
- `mem_we`, out, 1: 1 = write, 0 = read.
- `mem_req`, out, 1: transaction request.
- `mem_ack`, in, 1: one-cycle completion strobe from memory.
- `mem_rdata`, in, WORD_SIZE: read data, valid when `mem_ack` is high.
- `err_clear`, in, 1: clears `bus_error`.
- `bus_error`, out, 1: sticky timeout flag.
- `buf_count`, out, $clog2(WBUF_DEPTH)+1: current write-buffer occupancy.

## Operation

**Processor side**
- The processor holds address, data and request stable while `DataWaitreq`=1.
- A request completes in the cycle it is high with `DataWaitreq`=0.
- If `WriteData` and `ReadData` are both high, the write wins and the read is ignored that cycle.

**Stores**
- `DataWaitreq` = registered `buf_count`==WBUF_DEPTH.
- When not full, {DataAddr, DataOut} is pushed at the clock edge.
- The full check uses the registered count: no push while full, even if a pop happens in the same cycle.
- Simultaneous push and pop leaves the count unchanged.

**Loads (strict ordering, no forwarding)**
- `DataWaitreq`=1 while `ReadData`=1 unless the state is RDONE.
- A load issues only when the buffer is empty and the FSM is IDLE.

**FSM states and transitions**
- IDLE → WRITE when count>0. Buffer drain has priority over loads.
- IDLE → READ when count==0, `ReadData`=1 and `WriteData`=0. `DataAddr` is latched on this transition.
- WRITE: `mem_req`=1, `mem_we`=1, addr/data taken from the buffer head. On `mem_ack`, pop the head → IDLE.
- READ: `mem_req`=1, `mem_we`=0, `mem_addr` = latched address. On `mem_ack`, capture `mem_rdata` into rdata_q → RDONE.
- RDONE: `DataIn` = rdata_q, `DataWaitreq`=0 → IDLE.
- `mem_req` is low in IDLE and RDONE, so there is at least one idle cycle between transactions.
- `mem_addr`, `mem_wdata` and `mem_we` stay stable while `mem_req`=1.

**Timeout**
- A counter increments each cycle `mem_req`=1 and `mem_ack`=0, and clears on leaving WRITE/READ.
- When the count reaches TIMEOUT: `bus_error` is set.
  - WRITE: the head entry is popped (discarded) → IDLE.
  - READ: rdata_q = ERR_DATA → RDONE.
- `mem_ack` arriving in the same cycle as the timeout wins; no error is raised.
- `err_clear` clears `bus_error`. A simultaneous new timeout wins (the flag stays 1).

**Reset**
- Asynchronous reset, including mid-transaction: state=IDLE, buffer emptied, the in-flight memory transaction is abandoned.
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `DataIn`=0, `bus_error`=0, `buf_count`=0. `DataWaitreq` is 0 unless `ReadData` is high.

## Timing

- **Store acceptance:** 0 wait cycles when not full. Count updates at the next edge. `mem_req` rises 2 cycles after the push edge (count is seen in IDLE one cycle, then WRITE).
- **Load with empty buffer and `mem_ack` in the first READ cycle:**
  - cycle 0: `ReadData` seen.
  - cycle 1: READ with `mem_req`.
  - cycle 2: RDONE, `DataWaitreq`=0, data valid.
  - Minimum load latency is 2 stall cycles plus memory latency L.
- **Load behind k buffered stores:** waits for k full drains, each taking L+2 cycles including IDLE.
- **Pointer arithmetic:** head and tail pointers are $clog2(WBUF_DEPTH) bits and wrap modulo WBUF_DEPTH. The count is one bit wider.

## Structure

- Shared package `mem_pkg` (alongside the processor's WORD_SIZE): `bridge_state_t` enum {BR_IDLE, BR_WRITE, BR_READ, BR_RDONE} and the ERR_DATA constant.
- One sub-module, `write_buffer`: a synchronous FIFO with push/pop/full/empty/count, storing {addr, data}, async reset. The FSM, timeout counter and rdata_q live in `data_mem_bridge`.

## Test plan

- **Store burst:** five stores to 0x10..0x14, mem_ack L=3, WBUF_DEPTH=4. The first four stores take 0 wait cycles; the fifth sees `DataWaitreq`=1 until the first pop. Memory sees writes to 0x10..0x14 in order.
- **Load ordering:** store 0x20←0x1234, then load 0x20. The load stalls until the drain ack, then `mem_req` read to 0x20. Memory returns 0x1234 → `DataIn`=0x1234 in RDONE.
- **Minimum load:** buffer empty, ack in the first READ cycle, rdata=0xBEEF. `DataWaitreq` is high for exactly 2 cycles and `DataIn`=0xBEEF on cycle 2.
- **Timeout:** TIMEOUT=8, no ack on a load. `mem_req` is high 8 cycles and then drops. `DataIn`=0xDEAD and `bus_error`=1. `err_clear` → 0.
- **Write timeout:** no ack on a drained store. The entry is discarded, `buf_count` decrements, `bus_error`=1, and the next entry issues.
- **Reset mid-operation:** assert Reset during READ with 2 buffered stores. Immediately `mem_req`=0 and `buf_count`=0. After release, state is IDLE and no stale write issues.
